// File: rtl/pagerank_gather.sv
// pagerank_gather
//
// Gather-phase consumer for the pagerank scatter engine, one instance per
// partition. It sums the (node_id, contribution) stream from the scatter
// unit into one accumulator per node. When scatter signals completion, it
// streams pr_new = TELEPORT + DAMPING*acc, one rank per node, to the rank
// store in node order.
//
// Ports:
//   clock, reset_n        rising-edge clock; asynchronous active-low reset
//   start                 begins an iteration (sampled in IDLE only)
//   in_valid/in_ready     contribution handshake (in_ready high only in ACCUM)
//   in_node_id/in_contrib destination node and contribution value
//   scatter_done          level; scatter finished for this iteration
//   out_valid/out_ready   updated-rank handshake
//   out_node_id           node index of out_pagerank
//   out_pagerank          updated rank
//   busy                  high in any state except IDLE
//   iteration_done        one-cycle pulse after the last rank transfers
//   err_bad_id            sticky flag; an out-of-range id was dropped
module pagerank_gather #(
  parameter int unsigned       NUM_NODES = 16,
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       FRAC_W    = 32,
  parameter logic [DATA_W-1:0] DAMPING   = 64'h0000_0000_D999_999A,
  parameter logic [DATA_W-1:0] TELEPORT  = 64'h0000_0000_0266_6666
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_node_id,
  input  logic [DATA_W-1:0] in_contrib,
  input  logic              scatter_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_node_id,
  output logic [DATA_W-1:0] out_pagerank,
  output logic              busy,
  output logic              iteration_done,
  output logic              err_bad_id
);

  localparam int unsigned IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    APPLY = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] acc [NUM_NODES];
  logic [IDX_W-1:0]  k;
  logic [IDX_W-1:0]  in_idx;
  logic              id_ok;
  logic              in_xfer;
  logic              out_xfer;
  logic              last_node;

  // Accumulator add that sticks at all-ones instead of wrapping.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
  endfunction

  // Damping: TELEPORT + ((DAMPING*a) >> FRAC_W) with a full-width product;
  // anything that does not fit in DATA_W bits saturates to all-ones.
  function automatic logic [DATA_W-1:0] damp_apply(input logic [DATA_W-1:0] a);
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W:0]   sum;
    prod = (2*DATA_W)'(DAMPING) * (2*DATA_W)'(a);
    sum  = {1'b0, prod >> FRAC_W} + (2*DATA_W+1)'(TELEPORT);
    return (|sum[2*DATA_W:DATA_W]) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
  endfunction

  assign id_ok     = (in_node_id < 32'(NUM_NODES));
  assign in_idx    = in_node_id[IDX_W-1:0];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign last_node = (k == LAST_IDX);

  // Control state: FSM register, output index and sticky error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      k          <= '0;
      err_bad_id <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        err_bad_id <= 1'b0;
      end else if (in_xfer && !id_ok) begin
        err_bad_id <= 1'b1;
      end
      if (state == ACCUM) begin
        k <= '0;
      end else if (out_xfer) begin
        k <= last_node ? '0 : k + 1'b1;
      end
    end
  end

  // Accumulator bank: parallel clear in CLEAR, one saturating add per beat.
  // A beat arriving with scatter_done still lands because ACCUM is the
  // current state on that edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_NODES); i++) acc[i] <= '0;
    end else if (state == CLEAR) begin
      for (int i = 0; i < int'(NUM_NODES); i++) acc[i] <= '0;
    end else if (in_xfer && id_ok) begin
      acc[in_idx] <= sat_add(acc[in_idx], in_contrib);
    end
  end

  // Next state and outputs. The rank output is a function of the held
  // index k, so it stays stable while the consumer stalls.
  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_node_id    = '0;
    out_pagerank   = '0;
    busy           = 1'b1;
    iteration_done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: state_nxt = ACCUM;
      ACCUM: begin
        in_ready = 1'b1;
        if (scatter_done) state_nxt = APPLY;
      end
      APPLY: begin
        out_valid    = 1'b1;
        out_node_id  = 32'(k);
        out_pagerank = damp_apply(acc[k]);
        if (out_ready && last_node) state_nxt = DONE;
      end
      DONE: begin
        iteration_done = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pagerank_gather.sv
// Directed testbench for pagerank_gather with NUM_NODES=4 and
// TELEPORT=0x0999_9999. Inputs change on the falling edge; outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_pagerank_gather;

  localparam int unsigned       NN   = 4;
  localparam logic [63:0]       TEL  = 64'h0000_0000_0999_9999;
  localparam logic [63:0]       R1   = 64'h0000_0000_E333_3333;
  // acc = all-ones: (0xD999999A*(2^64-1))>>32 = 0xD9999999_FFFFFFFF, + TEL
  localparam logic [63:0]       RSAT = 64'hD999_999A_0999_9998;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_node_id;
  logic [63:0] in_contrib;
  logic        scatter_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_node_id;
  logic [63:0] out_pagerank;
  logic        busy;
  logic        iteration_done;
  logic        err_bad_id;

  int          n_cmp;
  int          n_err;
  logic [63:0] exp_rank [NN];

  pagerank_gather #(
    .NUM_NODES(NN),
    .DATA_W   (64),
    .FRAC_W   (32),
    .DAMPING  (64'h0000_0000_D999_999A),
    .TELEPORT (TEL)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_node_id    (in_node_id),
    .in_contrib    (in_contrib),
    .scatter_done  (scatter_done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_node_id   (out_node_id),
    .out_pagerank  (out_pagerank),
    .busy          (busy),
    .iteration_done(iteration_done),
    .err_bad_id    (err_bad_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ranks(input logic [63:0] r0, input logic [63:0] r1,
                           input logic [63:0] r2, input logic [63:0] r3);
    exp_rank[0] = r0;
    exp_rank[1] = r1;
    exp_rank[2] = r2;
    exp_rank[3] = r3;
  endtask

  // start -> CLEAR -> ACCUM; returns at the falling edge inside ACCUM.
  task automatic begin_iter();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_val("busy_clear", 64'(busy), 64'd1);
    check_val("err_cleared", 64'(err_bad_id), 64'd0);
    @(negedge clock);
    check_val("in_ready_accum", 64'(in_ready), 64'd1);
  endtask

  task automatic send(input logic [31:0] id, input logic [63:0] val);
    in_valid   = 1'b1;
    in_node_id = id;
    in_contrib = val;
    @(negedge clock);
    in_valid   = 1'b0;
  endtask

  // Raises scatter_done (optionally with a last beat in the same cycle),
  // then collects all ranks, stalling stall_cycles on stall_node. Latency
  // counts the scatter_done cycle as cycle 1 through the iteration_done cycle.
  task automatic drain(input int stall_node, input int stall_cycles,
                       input logic simul, input logic [31:0] sid,
                       input logic [63:0] sval);
    int          cyc;
    int          idx;
    int          stalls;
    logic [63:0] er;
    scatter_done = 1'b1;
    out_ready    = 1'b1;
    if (simul) begin
      in_valid   = 1'b1;
      in_node_id = sid;
      in_contrib = sval;
    end
    idx    = 0;
    stalls = 0;
    @(negedge clock);
    scatter_done = 1'b0;
    in_valid     = 1'b0;
    cyc          = 2;
    while (!iteration_done && cyc < 40) begin
      check_val("in_ready_apply", 64'(in_ready), 64'd0);
      check_val("out_valid_apply", 64'(out_valid), 64'd1);
      er = (idx < int'(NN)) ? exp_rank[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
      check_val("out_node_id", 64'(out_node_id), 64'(idx));
      check_val("out_pagerank", out_pagerank, er);
      if (idx == stall_node && stalls < stall_cycles) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
        idx++;
      end
      @(negedge clock);
      cyc++;
    end
    out_ready = 1'b1;
    check_val("done_latency", 64'(cyc), 64'(6 + stall_cycles));
    check_val("ranks_sent", 64'(idx), 64'(NN));
    check_val("out_valid_done", 64'(out_valid), 64'd0);
    @(negedge clock);
    check_val("done_one_pulse", 64'(iteration_done), 64'd0);
    check_val("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    n_cmp        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    start        = 1'b0;
    in_valid     = 1'b0;
    in_node_id   = '0;
    in_contrib   = '0;
    scatter_done = 1'b0;
    out_ready    = 1'b1;

    #2;
    check_val("rst_in_ready", 64'(in_ready), 64'd0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_iter_done", 64'(iteration_done), 64'd0);
    check_val("rst_err", 64'(err_bad_id), 64'd0);
    check_val("rst_out_id", 64'(out_node_id), 64'd0);
    check_val("rst_out_rank", out_pagerank, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic: two back-to-back beats to node 1.
    begin_iter();
    send(32'd1, 64'h8000_0000);
    send(32'd1, 64'h8000_0000);
    set_ranks(TEL, R1, TEL, TEL);
    drain(-1, 0, 1'b0, 32'd0, 64'd0);
    check_val("basic_err", 64'(err_bad_id), 64'd0);

    // Backpressure: node 1 held for 3 cycles.
    begin_iter();
    send(32'd1, 64'h8000_0000);
    send(32'd1, 64'h8000_0000);
    drain(1, 3, 1'b0, 32'd0, 64'd0);

    // Bad id: dropped, error sticky until the next start.
    begin_iter();
    send(32'd7, 64'h1_0000_0000);
    check_val("bad_id_err", 64'(err_bad_id), 64'd1);
    set_ranks(TEL, TEL, TEL, TEL);
    drain(-1, 0, 1'b0, 32'd0, 64'd0);
    @(negedge clock);
    check_val("bad_id_sticky", 64'(err_bad_id), 64'd1);

    // Simultaneous last beat and scatter_done.
    begin_iter();
    set_ranks(TEL, TEL, R1, TEL);
    drain(-1, 0, 1'b1, 32'd2, 64'h1_0000_0000);

    // Saturation of the accumulator.
    begin_iter();
    send(32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    send(32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    set_ranks(RSAT, TEL, TEL, TEL);
    drain(-1, 0, 1'b0, 32'd0, 64'd0);

    // Reset in the middle of APPLY.
    begin_iter();
    send(32'd1, 64'h8000_0000);
    scatter_done = 1'b1;
    out_ready    = 1'b1;
    @(negedge clock);
    scatter_done = 1'b0;
    cyc = 0;
    while (!(out_valid && out_node_id == 32'd2) && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check_val("mid_reach_node2", 64'(out_node_id), 64'd2);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_rank", out_pagerank, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_val("post_rst_out_valid", 64'(out_valid), 64'd0);
    check_val("post_rst_iter_done", 64'(iteration_done), 64'd0);
    begin_iter();
    set_ranks(TEL, TEL, TEL, TEL);
    drain(-1, 0, 1'b0, 32'd0, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
